// File: rtl/axis_frame_gen_if.sv
// ---------------------------------------------------------------------------
// axis_frame_gen_if
//   AXI4-Stream bundle used between the frame generator and its sink.
//   master : drives tdata/tkeep/tvalid/tlast/tid/tdest/tuser, samples tready
//   slave  : the mirror image
// ---------------------------------------------------------------------------
interface axis_frame_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = 1,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport master (
      output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/axis_frame_gen.sv
// ---------------------------------------------------------------------------
// axis_frame_gen
//   AXI4-Stream frame source for bring-up/regression of the FIFO path.
//   A start pulse in IDLE latches frame_len/frame_count/seed/mark_bad/
//   cfg_id/cfg_dest and emits frame_count frames of frame_len bytes.
//   Byte k of frame f is (seed + f + k) mod 256. The last beat of a frame
//   carries a partial tkeep (unused lanes zeroed), tlast, and the bad-frame
//   tuser marker when mark_bad was latched.
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     start         run trigger, honoured only in IDLE
//     frame_len     bytes per frame
//     frame_count   frames per run
//     seed          pattern seed
//     mark_bad      tag every frame's last beat with USER_BAD_FRAME_VALUE
//     cfg_id/dest   tid/tdest for the run
//     m_axis        AXI4-Stream master
//     busy          run in progress
//     done          one-cycle pulse at run completion
//     frames_sent   running count of accepted tlast beats
// ---------------------------------------------------------------------------

// One byte lane of the next beat: lane LANE is live when it lies below the
// number of valid bytes nb; dead lanes carry zero.
module axis_frame_gen_lane #(
   parameter int LANE = 0,
   parameter int NBW  = 1
) (
   input  logic [7:0]     base,
   input  logic [NBW-1:0] nb,
   output logic [7:0]     lane_byte,
   output logic           keep
);
   assign keep      = NBW'(LANE) < nb;
   assign lane_byte = keep ? base + 8'(LANE) : 8'd0;
endmodule

module axis_frame_gen #(
   parameter int DATA_WIDTH  = 8,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int ID_ENABLE   = 0,
   parameter int ID_WIDTH    = 8,
   parameter int DEST_ENABLE = 0,
   parameter int DEST_WIDTH  = 8,
   parameter int USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1,
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  frame_len,
   input  logic [15:0]           frame_count,
   input  logic [7:0]            seed,
   input  logic                  mark_bad,
   input  logic [ID_WIDTH-1:0]   cfg_id,
   input  logic [DEST_WIDTH-1:0] cfg_dest,
   axis_frame_gen_if.master      m_axis,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           frames_sent
);
   localparam int KW   = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 1;
   localparam int WORD = DATA_WIDTH / KW;
   localparam int NBW  = $clog2(KW + 1);

   generate
      if (WORD != 8) begin : g_bad_word
         initial begin
            $error("axis_frame_gen: word size must be 8 bits");
            $finish;
         end
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
   state_t state;

   // latched run configuration
   logic [LEN_WIDTH-1:0]  len_r;
   logic [15:0]           cnt_r;
   logic                  bad_r;
   logic [ID_WIDTH-1:0]   tid_r;
   logic [DEST_WIDTH-1:0] tdest_r;

   // frame/beat tracking: fbase_r = seed+f, bbase_r = first byte of the
   // current beat, rem_r = bytes left in the frame including this beat
   logic [15:0]           fidx_r;
   logic [7:0]            fbase_r;
   logic [7:0]            bbase_r;
   logic [LEN_WIDTH-1:0]  rem_r;

   // registered stream outputs
   logic [KW-1:0][7:0]    tdata_r;
   logic [KW-1:0]         tkeep_r;
   logic                  tvalid_r;
   logic                  tlast_r;
   logic [USER_WIDTH-1:0] tuser_r;

   // next-beat generator
   logic [7:0]            gen_base;
   logic [LEN_WIDTH-1:0]  gen_rem;
   logic                  gen_bad;
   logic                  gen_last;
   logic [NBW-1:0]        gen_nb;
   logic [KW-1:0][7:0]    gen_bytes;
   logic [KW-1:0]         gen_keep;

   logic accept, fin_frame, cfg_empty, load;

   assign accept    = tvalid_r && m_axis.tready;
   assign fin_frame = tlast_r && (fidx_r == cnt_r - 16'd1);
   assign cfg_empty = (frame_len == '0) || (frame_count == '0);
   // a new beat is loaded either from the live cfg inputs at start, or
   // from the running counters when the current beat is taken
   assign load      = (state == IDLE && start && !done && !cfg_empty) ||
                      (state == SEND && accept && !fin_frame);

   always_comb begin
      gen_base = bbase_r + 8'(KW);
      gen_rem  = rem_r - LEN_WIDTH'(KW);
      gen_bad  = bad_r;
      if (state == IDLE) begin
         gen_base = seed;
         gen_rem  = frame_len;
         gen_bad  = mark_bad;
      end else if (tlast_r) begin
         gen_base = fbase_r + 8'd1;
         gen_rem  = len_r;
      end
   end

   assign gen_last = gen_rem <= LEN_WIDTH'(KW);
   assign gen_nb   = gen_last ? NBW'(gen_rem) : NBW'(KW);

   generate
      for (genvar i = 0; i < KW; i++) begin : g_lane
         axis_frame_gen_lane #(.LANE(i), .NBW(NBW)) u_lane (
            .base      (gen_base),
            .nb        (gen_nb),
            .lane_byte (gen_bytes[i]),
            .keep      (gen_keep[i])
         );
      end
   endgenerate

   // control FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tvalid_r    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frames_sent <= '0;
         len_r       <= '0;
         cnt_r       <= '0;
         bad_r       <= 1'b0;
         tid_r       <= '0;
         tdest_r     <= '0;
         fidx_r      <= '0;
         fbase_r     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // busy stays up through the done cycle; start is ignored there
               if (done) begin
                  busy <= 1'b0;
               end else if (start) begin
                  len_r   <= frame_len;
                  cnt_r   <= frame_count;
                  bad_r   <= mark_bad;
                  tid_r   <= cfg_id;
                  tdest_r <= cfg_dest;
                  fidx_r  <= '0;
                  fbase_r <= seed;
                  busy    <= 1'b1;
                  if (cfg_empty) begin
                     state <= FIN;
                  end else begin
                     state    <= SEND;
                     tvalid_r <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (accept && tlast_r) begin
                  frames_sent <= frames_sent + 32'd1;
                  if (fin_frame) begin
                     state    <= FIN;
                     tvalid_r <= 1'b0;
                  end else begin
                     fidx_r  <= fidx_r + 16'd1;
                     fbase_r <= fbase_r + 8'd1;
                  end
               end
            end
            FIN: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // beat datapath: only changes on load, so stalls hold everything
   always_ff @(posedge clk) begin
      if (rst) begin
         tdata_r <= '0;
         tkeep_r <= '0;
         tlast_r <= 1'b0;
         tuser_r <= '0;
         bbase_r <= '0;
         rem_r   <= '0;
      end else if (load) begin
         tdata_r <= gen_bytes;
         tkeep_r <= gen_keep;
         tlast_r <= gen_last;
         tuser_r <= (USER_ENABLE != 0 && gen_last && gen_bad) ? USER_BAD_FRAME_VALUE : '0;
         bbase_r <= gen_base;
         rem_r   <= gen_rem;
      end else if (state == SEND && accept) begin
         tlast_r <= 1'b0;
         tuser_r <= '0;
      end
   end

   assign m_axis.tdata  = DATA_WIDTH'(tdata_r);
   assign m_axis.tvalid = tvalid_r;
   assign m_axis.tlast  = tlast_r;
   assign m_axis.tuser  = tuser_r;
   assign m_axis.tid    = (ID_ENABLE != 0)   ? tid_r   : '0;
   assign m_axis.tdest  = (DEST_ENABLE != 0) ? tdest_r : '0;

   generate
      if (KEEP_ENABLE != 0) begin : g_keep
         assign m_axis.tkeep = tkeep_r;
      end else begin : g_no_keep
         assign m_axis.tkeep = '1;
      end
   endgenerate
endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen with 32-bit data, tkeep, tid and tdest enabled.
module tb_axis_frame_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] frame_len = '0;
   logic [15:0] frame_count = '0;
   logic [7:0]  seed = '0;
   logic        mark_bad = 1'b0;
   logic [7:0]  cfg_id = '0;
   logic [7:0]  cfg_dest = '0;
   logic        busy, done;
   logic [31:0] frames_sent;

   axis_frame_gen_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8),
                       .DEST_WIDTH(8), .USER_WIDTH(1)) axis ();

   axis_frame_gen #(.DATA_WIDTH(32), .ID_ENABLE(1), .DEST_ENABLE(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .frame_len   (frame_len),
      .frame_count (frame_count),
      .seed        (seed),
      .mark_bad    (mark_bad),
      .cfg_id      (cfg_id),
      .cfg_dest    (cfg_dest),
      .m_axis      (axis),
      .busy        (busy),
      .done        (done),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endfunction

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
   } beat_t;
   beat_t exp_q[$];

   // reference: every beat of the run straight from the byte formula
   function automatic void build(input int len, input int cnt, input int sd, input bit bad);
      beat_t b;
      int nb;
      exp_q.delete();
      if (len == 0) return;
      nb = (len + 3) / 4;
      for (int f = 0; f < cnt; f++)
         for (int bi = 0; bi < nb; bi++) begin
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < 4; i++) begin
               int k = bi * 4 + i;
               if (k < len) begin
                  b.data[i*8 +: 8] = 8'((sd + f + k) % 256);
                  b.keep[i] = 1'b1;
               end
            end
            b.last = (bi == nb - 1);
            b.user = b.last && bad;
            exp_q.push_back(b);
         end
   endfunction

   function automatic logic [54:0] snap_out();
      return {axis.tdata, axis.tkeep, axis.tlast, axis.tuser, axis.tid, axis.tdest, axis.tvalid};
   endfunction

   task automatic rand_cfg();
      frame_len = 16'($urandom); frame_count = 16'($urandom); seed = 8'($urandom);
      mark_bad = 1'($urandom); cfg_id = 8'($urandom); cfg_dest = 8'($urandom);
   endtask

   // rmode: 0 always ready, 1 toggle 1,0,1,0..., 2 random
   task automatic run(input int len, input int cnt, input logic [7:0] sd, input logic bad,
                      input int rmode, output int nacc, output logic [31:0] d_first,
                      output logic [31:0] d_last, output logic [3:0] k_last);
      int cyc, done_cyc, end_cyc, nframes;
      logic [7:0] id, dst;
      logic [31:0] fs0;
      logic [54:0] snap;
      logic stalled, r;
      beat_t b;
      build(len, cnt, sd, bad);
      nframes = (len == 0) ? 0 : cnt;
      id = 8'($urandom); dst = 8'($urandom); fs0 = frames_sent;
      frame_len = 16'(len); frame_count = 16'(cnt); seed = sd; mark_bad = bad;
      cfg_id = id; cfg_dest = dst; start = 1'b1; axis.tready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      rand_cfg();
      nacc = 0; d_first = '0; d_last = '0; k_last = '0;
      done_cyc = -1; end_cyc = (exp_q.size() == 0) ? 0 : -1; stalled = 1'b0; snap = '0;
      for (cyc = 1; cyc < 3000; cyc++) begin
         if (stalled) chk("stall_hold", 64'(snap_out()), 64'(snap));
         if (end_cyc < 0) chk("tvalid_held", axis.tvalid, 1);
         else chk("tvalid_low", axis.tvalid, 0);
         if (end_cyc >= 0 && cyc == end_cyc + 2) begin
            chk("done_pulse", done, 1);
            done_cyc = cyc;
         end else chk("done_low", done, 0);
         chk("busy_high", busy, 1);
         case (rmode)
            0: r = 1'b1;
            1: r = cyc[0];
            default: r = ($urandom_range(0, 2) != 0);
         endcase
         axis.tready = r;
         // stray starts while busy, plus one exactly in the done cycle
         start = (done_cyc < 0 && $urandom_range(0, 7) == 0) || (cyc == done_cyc);
         if (start) rand_cfg();
         stalled = axis.tvalid && !r;
         snap = snap_out();
         if (axis.tvalid && r) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else begin
               b = exp_q.pop_front();
               chk("tdata", axis.tdata, b.data);
               chk("tkeep", axis.tkeep, b.keep);
               chk("tlast", axis.tlast, b.last);
               chk("tuser", axis.tuser, b.user);
               chk("tid", axis.tid, id);
               chk("tdest", axis.tdest, dst);
               if (nacc == 0) d_first = axis.tdata;
               d_last = axis.tdata; k_last = axis.tkeep;
               nacc++;
               if (exp_q.size() == 0) end_cyc = cyc;
            end
         end
         if (done_cyc >= 0) break;
         @(negedge clk);
      end
      chk("run_timeout", done_cyc >= 0, 1);
      @(negedge clk);
      start = 1'b0;
      axis.tready = 1'b0;
      chk("busy_clear", busy, 0);
      chk("done_single", done, 0);
      chk("frames_sent", frames_sent, fs0 + 32'(nframes));
      @(negedge clk);
      chk("start_in_done_ignored", {busy, axis.tvalid}, 2'b00);
   endtask

   typedef struct {
      int          len;
      int          cnt;
      logic [7:0]  sd;
      logic        bad;
      int          rmode;
      int          exp_beats;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      logic [3:0]  exp_lkeep;
   } vec_t;
   vec_t vecs[7];

   initial begin
      int nacc, len, cnt, eb;
      logic [31:0] df, dl;
      logic [3:0] kl;
      vecs[0] = '{10, 1, 8'h10, 1'b0, 0, 3, 32'h13121110, 32'h00001918, 4'h3};
      vecs[1] = '{ 8, 2, 8'h00, 1'b0, 0, 4, 32'h03020100, 32'h08070605, 4'hF};
      vecs[2] = '{10, 1, 8'h10, 1'b0, 1, 3, 32'h13121110, 32'h00001918, 4'h3};
      vecs[3] = '{ 4, 1, 8'hFE, 1'b1, 0, 1, 32'h0100FFFE, 32'h0100FFFE, 4'hF};
      vecs[4] = '{ 0, 3, 8'h55, 1'b0, 0, 0, 32'h0, 32'h0, 4'h0};
      vecs[5] = '{ 5, 0, 8'h55, 1'b1, 0, 0, 32'h0, 32'h0, 4'h0};
      vecs[6] = '{ 1, 3, 8'hAA, 1'b1, 2, 3, 32'h000000AA, 32'h000000AC, 4'h1};
      axis.tready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_outputs", {axis.tvalid, axis.tlast, axis.tdata, axis.tkeep, axis.tid,
                          axis.tdest, axis.tuser, busy, done}, '0);
      chk("rst_frames_sent", frames_sent, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[v]) begin
         run(vecs[v].len, vecs[v].cnt, vecs[v].sd, vecs[v].bad, vecs[v].rmode, nacc, df, dl, kl);
         chk($sformatf("vec%0d_beats", v), nacc, vecs[v].exp_beats);
         if (vecs[v].exp_beats > 0) begin
            chk($sformatf("vec%0d_first", v), df, vecs[v].exp_first);
            chk($sformatf("vec%0d_last", v), dl, vecs[v].exp_last);
            chk($sformatf("vec%0d_lkeep", v), kl, vecs[v].exp_lkeep);
         end
      end

      for (int t = 0; t < 25; t++) begin
         len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
         cnt = $urandom_range(0, 4);
         eb  = (len == 0) ? 0 : cnt * ((len + 3) / 4);
         run(len, cnt, 8'($urandom), 1'($urandom), $urandom_range(0, 2), nacc, df, dl, kl);
         chk("rand_beats", nacc, eb);
      end

      // reset during the second beat of a 3-beat frame
      frame_len = 16'd10; frame_count = 16'd1; seed = 8'h10; mark_bad = 1'b0;
      start = 1'b1; axis.tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_beat1", axis.tdata, 32'h17161514);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_state", {axis.tvalid, busy, done}, 3'b000);
      chk("midrst_frames_sent", frames_sent, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", {axis.tvalid, busy, done}, 3'b000);
      end
      run(10, 1, 8'h10, 1'b0, 0, nacc, df, dl, kl);
      chk("fresh_beats", nacc, 3);
      chk("fresh_last", dl, 32'h00001918);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end
endmodule
